// File: rtl/excp_irq_ctrl_n_if.sv
// Trap-side bundle of excp_irq_ctrl_n: exception request in, flush handshake out.
// master = the controller, slave = exception producer / PC unit.
interface excp_irq_ctrl_n_if #(
    parameter int NUM_IRQ = 8,
    parameter int XLEN    = 32
);
    logic               excp_req_i;
    logic [XLEN-1:0]    excp_cause_i;
    logic [XLEN-1:0]    epc_i;
    logic               excp_ready_o;
    logic               flush_req_o;
    logic [XLEN-1:0]    flush_addr_o;
    logic [NUM_IRQ-1:0] irq_claim_o;
    logic               flush_ack_i;

    modport master (
        input  excp_req_i, excp_cause_i, epc_i, flush_ack_i,
        output excp_ready_o, flush_req_o, flush_addr_o, irq_claim_o
    );

    modport slave (
        output excp_req_i, excp_cause_i, epc_i, flush_ack_i,
        input  excp_ready_o, flush_req_o, flush_addr_o, irq_claim_o
    );
endinterface

// File: rtl/excp_irq_ctrl_n.sv
// Exception/interrupt trap controller with WFI handling.
// Define EXCP_IRQ_VECTORED_EN to honour mtvec vectored mode for interrupts.
module excp_irq_ctrl_n #(
    parameter int NUM_IRQ        = 8,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter int XLEN           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               status_mie_r,
    input  logic               dbg_mode,
    input  logic [XLEN-1:0]    csr_mtvec_r,
    input  logic               wfi_i,
    input  logic               wfi_halt_ack,
    excp_irq_ctrl_n_if.master  trap_if,
    output logic [XLEN-1:0]    cmt_cause_o,
    output logic               cmt_cause_ena,
    output logic [XLEN-1:0]    cmt_epc_o,
    output logic               cmt_epc_ena,
    output logic               cmt_status_ena,
    output logic               core_wfi
);
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        WFI_REQ,
        WFI_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] claim_q, claim_d;
    logic [XLEN-1:0]    cause_q, cause_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic               ready_q, ready_d;
    logic               flush_q, flush_d;
    logic               wfi_q, wfi_d;

    logic [NUM_IRQ-1:0] woke;
    logic [NUM_IRQ-1:0] elig;
    logic [IW-1:0]      idx;
    logic [XLEN-1:0]    code;
    logic [XLEN-1:0]    base;
    logic [XLEN-1:0]    irq_addr;
    logic               done;

    // woke ignores mie: it only ends WFI, it never takes a trap
    assign woke = pend_q & irq_en_i;
    assign elig = woke & {NUM_IRQ{status_mie_r & ~dbg_mode}};
    assign base = {csr_mtvec_r[XLEN-1:2], 2'b00};
    assign code = XLEN'(IRQ_CAUSE_BASE) + XLEN'(idx);
    assign done = flush_q & trap_if.flush_ack_i;

`ifdef EXCP_IRQ_VECTORED_EN
    assign irq_addr = (csr_mtvec_r[1:0] == 2'b01) ? base + (code << 2) : base;
`else
    logic unused_mode;
    assign unused_mode = ^csr_mtvec_r[1:0];
    assign irq_addr    = base;
`endif

    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) idx = IW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = irq_i | (pend_q & ~(done ? claim_q : '0));
        claim_d = claim_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = TRAP;
                    claim_d = NUM_IRQ'(1) << idx;
                    cause_d = {1'b1, code[XLEN-2:0]};
                    epc_d   = trap_if.epc_i;
                    addr_d  = irq_addr;
                end else if (trap_if.excp_req_i) begin
                    state_d = TRAP;
                    claim_d = '0;
                    cause_d = {1'b0, trap_if.excp_cause_i[XLEN-2:0]};
                    epc_d   = trap_if.epc_i;
                    addr_d  = base;
                end else if (wfi_i) begin
                    state_d = WFI_REQ;
                end
            end
            TRAP: begin
                if (done) begin
                    state_d = IDLE;
                    claim_d = '0;
                    addr_d  = '0;
                end
            end
            WFI_REQ: begin
                if (|woke) state_d = IDLE;
                else if (wfi_halt_ack) state_d = WFI_HALT;
            end
            WFI_HALT: begin
                if (|woke) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        flush_d = (state_d == TRAP);
        wfi_d   = (state_d == WFI_REQ) || (state_d == WFI_HALT);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            claim_q <= '0;
            cause_q <= '0;
            epc_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            flush_q <= 1'b0;
            wfi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            claim_q <= claim_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            flush_q <= flush_d;
            wfi_q   <= wfi_d;
        end
    end

    assign trap_if.excp_ready_o = ready_q;
    assign trap_if.flush_req_o  = flush_q;
    assign trap_if.flush_addr_o = addr_q;
    assign trap_if.irq_claim_o  = claim_q;

    assign cmt_cause_o    = cause_q;
    assign cmt_epc_o      = epc_q;
    assign cmt_cause_ena  = done & ~rst;
    assign cmt_epc_ena    = done & ~rst;
    assign cmt_status_ena = done & ~rst;
    assign core_wfi       = wfi_q;
endmodule

// File: tb/tb_excp_irq_ctrl_n.sv
// Bench for excp_irq_ctrl_n: directed scenarios plus random traffic
// compared every cycle against a trap-level reference model.
module tb_excp_irq_ctrl_n;
    localparam int NI   = 8;
    localparam int XL   = 32;
    localparam int BASE = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] irq_i;
    logic [NI-1:0] irq_en_i;
    logic          mie;
    logic          dbg;
    logic [XL-1:0] mtvec;
    logic          wfi;
    logic          hack;
    logic [XL-1:0] cmt_cause_o;
    logic          cmt_cause_ena;
    logic [XL-1:0] cmt_epc_o;
    logic          cmt_epc_ena;
    logic          cmt_status_ena;
    logic          core_wfi;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    excp_irq_ctrl_n_if #(.NUM_IRQ(NI), .XLEN(XL)) bus ();

    excp_irq_ctrl_n #(
        .NUM_IRQ(NI),
        .IRQ_CAUSE_BASE(BASE),
        .XLEN(XL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_i(irq_i),
        .irq_en_i(irq_en_i),
        .status_mie_r(mie),
        .dbg_mode(dbg),
        .csr_mtvec_r(mtvec),
        .wfi_i(wfi),
        .wfi_halt_ack(hack),
        .trap_if(bus),
        .cmt_cause_o(cmt_cause_o),
        .cmt_cause_ena(cmt_cause_ena),
        .cmt_epc_o(cmt_epc_o),
        .cmt_epc_ena(cmt_epc_ena),
        .cmt_status_ena(cmt_status_ena),
        .core_wfi(core_wfi)
    );

    // reference model: pending set, current trap record, waiting flag
    bit [NI-1:0] m_pend;
    bit          m_trap, m_wait, m_fresh, m_known;
    bit [31:0]   m_cause, m_epc, m_addr;
    bit [NI-1:0] m_claim;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit [31:0] vec_addr(int k);
        bit [31:0] b;
        b = mtvec & 32'hFFFF_FFFC;
`ifdef EXCP_IRQ_VECTORED_EN
        if (mtvec[1:0] == 2'b01) return b + 32'(4 * (BASE + k));
`endif
        return b;
    endfunction

    task automatic model_step();
        bit [NI-1:0] woke, elig, clr;
        int k;
        if (rst) begin
            m_pend  = '0;
            m_trap  = 0;
            m_wait  = 0;
            m_fresh = 1;
            m_known = 1;
            m_claim = '0;
            return;
        end
        m_fresh = 0;
        clr  = '0;
        woke = m_pend & irq_en_i;
        elig = (mie && !dbg) ? woke : '0;
        if (m_trap) begin
            if (bus.flush_ack_i) begin
                clr    = m_claim;
                m_trap = 0;
            end
        end else if (m_wait) begin
            if (woke != 0) m_wait = 0;
        end else if (elig != 0) begin
            k = 0;
            while (!elig[k]) k++;
            m_trap  = 1;
            m_claim = NI'(1) << k;
            m_cause = 32'h8000_0000 | 32'(BASE + k);
            m_epc   = bus.epc_i;
            m_addr  = vec_addr(k);
        end else if (bus.excp_req_i) begin
            m_trap  = 1;
            m_claim = '0;
            m_cause = bus.excp_cause_i & 32'h7FFF_FFFF;
            m_epc   = bus.epc_i;
            m_addr  = mtvec & 32'hFFFF_FFFC;
        end else if (wfi) begin
            m_wait = 1;
        end
        m_pend = (m_pend & ~clr) | irq_i;
    endtask

    task automatic check_outputs();
        bit ena;
        ena = m_trap && bus.flush_ack_i && !rst;
        chk("ready", bus.excp_ready_o, !m_trap && !m_wait && !m_fresh);
        chk("flush_req", bus.flush_req_o, m_trap);
        chk("flush_addr", bus.flush_addr_o, m_trap ? m_addr : 32'h0);
        chk("claim", bus.irq_claim_o, m_trap ? m_claim : '0);
        chk("core_wfi", core_wfi, m_wait);
        chk("cause_ena", cmt_cause_ena, ena);
        chk("epc_ena", cmt_epc_ena, ena);
        chk("status_ena", cmt_status_ena, ena);
        if (m_trap) begin
            chk("cause", cmt_cause_o, m_cause);
            chk("epc", cmt_epc_o, m_epc);
        end
    endtask

    task automatic tick();
        #1;
        if (m_known) check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst              = 1'b0;
        irq_i            = '0;
        irq_en_i         = '1;
        mie              = 1'b1;
        dbg              = 1'b0;
        mtvec            = 32'h8000_0000;
        wfi              = 1'b0;
        hack             = 1'b0;
        bus.excp_req_i   = 1'b0;
        bus.excp_cause_i = '0;
        bus.epc_i        = 32'h0000_1000;
        bus.flush_ack_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] a0;
        int pulses;
        quiet();
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_ready", bus.excp_ready_o, 1'b0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", bus.excp_ready_o, 1'b1);

        // channel 3: request visible two cycles after irq_i
        irq_i = 8'h08;
        tick();
        irq_i = '0;
        chk("r22_n1_req", bus.flush_req_o, 1'b0);
        tick();
        chk("r22_req", bus.flush_req_o, 1'b1);
        chk("r22_cause", cmt_cause_o, 32'h8000_0013);
        chk("r22_claim", bus.irq_claim_o, 8'h08);
        chk("r22_addr", bus.flush_addr_o, 32'h8000_0000);
        bus.flush_ack_i = 1'b1;
        #1;
        chk("r22_ena", cmt_cause_ena, 1'b1);
        tick();
        bus.flush_ack_i = 1'b0;
        chk("r22_idle", bus.flush_req_o, 1'b0);

        // interrupt beats a simultaneous exception; exception is lost
        irq_i = 8'h24;
        tick();
        bus.excp_req_i   = 1'b1;
        bus.excp_cause_i = 32'd2;
        tick();
        bus.excp_req_i = 1'b0;
        irq_i = '0;
        chk("r23_cause", cmt_cause_o, 32'h8000_0012);
        chk("r23_claim", bus.irq_claim_o, 8'h04);
        bus.flush_ack_i = 1'b1;
        tick();
        bus.flush_ack_i = 1'b0;
        tick();
        chk("r23_next_cause", cmt_cause_o, 32'h8000_0015);
        bus.flush_ack_i = 1'b1;
        tick();
        bus.flush_ack_i = 1'b0;
        tick();
        chk("r23_no_excp", bus.flush_req_o, 1'b0);

        // flush held pending for 5 cycles
        irq_i = 8'h02;
        tick();
        irq_i = '0;
        tick();
        a0 = bus.flush_addr_o;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chk("r24_hold_req", bus.flush_req_o, 1'b1);
            chk("r24_hold_addr", bus.flush_addr_o, a0);
            pulses += int'(cmt_cause_ena);
            tick();
        end
        bus.flush_ack_i = 1'b1;
        #1;
        pulses += int'(cmt_cause_ena);
        tick();
        bus.flush_ack_i = 1'b0;
        #1;
        pulses += int'(cmt_cause_ena);
        chk("r24_pulses", 64'(pulses), 64'd1);
        chk("r24_done", bus.flush_req_o, 1'b0);

        // vectored target for channel 1
        mtvec = 32'h8000_0001;
        irq_i = 8'h02;
        tick();
        irq_i = '0;
        tick();
`ifdef EXCP_IRQ_VECTORED_EN
        chk("r26_addr", bus.flush_addr_o, 32'h8000_0044);
`else
        chk("r26_addr", bus.flush_addr_o, 32'h8000_0000);
`endif
        bus.flush_ack_i = 1'b1;
        tick();
        bus.flush_ack_i = 1'b0;
        mtvec = 32'h8000_0000;

        // WFI woken by an interrupt while mie=0: no trap follows
        mie = 1'b0;
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        chk("r25_wfi", core_wfi, 1'b1);
        tick();
        tick();
        hack = 1'b1;
        tick();
        hack = 1'b0;
        chk("r25_halted", core_wfi, 1'b1);
        irq_i = 8'h01;
        tick();
        irq_i = '0;
        chk("r25_pend_seen", core_wfi, 1'b1);
        tick();
        chk("r25_wake", core_wfi, 1'b0);
        chk("r25_ready", bus.excp_ready_o, 1'b1);
        tick();
        tick();
        chk("r25_no_trap", bus.flush_req_o, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mie = 1'b1;
        tick();

        // reset abandons an unacknowledged trap
        irq_i = 8'h10;
        tick();
        irq_i = '0;
        tick();
        chk("r27_in_trap", bus.flush_req_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r27_req", bus.flush_req_o, 1'b0);
        chk("r27_ready", bus.excp_ready_o, 1'b0);
        chk("r27_claim", bus.irq_claim_o, 8'h00);
        tick();
        chk("r27_ready_after", bus.excp_ready_o, 1'b1);
        tick();
        chk("r27_pend_clear", bus.flush_req_o, 1'b0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            irq_i    = ($urandom_range(0, 3) == 0) ?
                       NI'($urandom) & NI'($urandom) : '0;
            irq_en_i = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '1;
            mie      = ($urandom_range(0, 7) != 0);
            dbg      = ($urandom_range(0, 15) == 0);
            mtvec    = $urandom;
            wfi      = ($urandom_range(0, 11) == 0);
            hack     = ($urandom_range(0, 2) == 0);
            bus.excp_req_i   = ($urandom_range(0, 5) == 0);
            bus.excp_cause_i = $urandom;
            bus.epc_i        = $urandom;
            bus.flush_ack_i  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
